// File: rtl/pulse_period_meter_pkg.sv
// ============================================================
// pulse_pkg : shared FSM encoding and defaults for the pulse generator/meter pair
// Rev 1.0
// ============================================================
`default_nettype none

package pulse_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam int          c_DEFAULT_WIDTH       = 32;
  localparam int          c_DEFAULT_SYNC_STAGES = 2;
  // 2 s at 50 MHz
  localparam logic [31:0] c_DEFAULT_TIMEOUT     = 32'd100000000;

endpackage

`default_nettype wire

// File: rtl/pulse_period_meter_if.sv
// ============================================================
// pulse_period_meter_if : pulse input, clear and measurement results
// Rev 1.0
// ============================================================
`default_nettype none

interface pulse_period_meter_if #(
  parameter int WIDTH = 32
);

  logic             pulse_in;
  logic             clear;
  logic             edge_strobe;
  logic             period_valid;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] pulse_count;
  logic             timeout;

  modport master (
    output pulse_in,
    output clear,
    input  edge_strobe,
    input  period_valid,
    input  period_out,
    input  pulse_count,
    input  timeout
  );

  modport slave (
    input  pulse_in,
    input  clear,
    output edge_strobe,
    output period_valid,
    output period_out,
    output pulse_count,
    output timeout
  );

endinterface

`default_nettype wire

// File: rtl/pulse_period_meter_sync_edge.sv
// ============================================================
// pulse_sync_edge : async input synchronizer with combinational rising-edge detect
// Rev 1.0
// ============================================================
`default_nettype none

module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_async,
  output logic      o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pulse_period_meter.sv
// ============================================================
// pulse_period_meter : counts rising edges of an async pulse and measures their spacing
// Rev 1.0
// ============================================================
`default_nettype none

module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int          WIDTH       = c_DEFAULT_WIDTH,
  parameter int          SYNC_STAGES = c_DEFAULT_SYNC_STAGES,
  parameter logic [31:0] TIMEOUT     = c_DEFAULT_TIMEOUT
) (
  input wire logic            clk,
  input wire logic            rst_n,
  pulse_period_meter_if.slave bus
);

  logic             w_rise;
  logic [WIDTH:0]   w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_sat;
  logic             w_timeout_hit;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_count;
  logic             r_timeout;
  logic             r_edge;
  logic             r_valid;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(bus.pulse_in),
    .o_rise (w_rise)
  );

  // The interval counter saturates so a narrow WIDTH still reports a pinned period.
  assign w_cnt_inc     = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign w_cnt_sat     = w_cnt_inc[WIDTH] ? {WIDTH{1'b1}} : w_cnt_inc[WIDTH-1:0];
  assign w_timeout_hit = (64'(w_cnt_inc) >= 64'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_count   <= '0;
      r_timeout <= 1'b0;
      r_edge    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (bus.clear) begin
      // A rise coincident with clear is dropped entirely.
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_count   <= '0;
      r_timeout <= 1'b0;
      r_edge    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_edge  <= w_rise;
      r_valid <= 1'b0;
      if (w_rise) begin
        r_count <= r_count + WIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_period <= w_cnt_sat;
            r_valid  <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= w_cnt_sat;
            if (w_timeout_hit) begin
              r_timeout <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.edge_strobe  = r_edge;
  assign bus.period_valid = r_valid;
  assign bus.period_out   = r_period;
  assign bus.pulse_count  = r_count;
  assign bus.timeout      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
// ============================================================
// tb_pulse_period_meter : scenario bench with an edge-time reference model
// Rev 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_period_meter;

  localparam int c_SYNC = 2;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  longint cyc  = 0;
  int    errs  = 0;
  int    checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_period_meter_if #(.WIDTH(32)) bus_a ();
  pulse_period_meter_if #(.WIDTH(4))  bus_b ();

  pulse_period_meter #(.WIDTH(32), .SYNC_STAGES(c_SYNC), .TIMEOUT(32'd50)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  pulse_period_meter #(.WIDTH(4), .SYNC_STAGES(c_SYNC), .TIMEOUT(32'd100000)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // Reference: remembers the clk edge of the last accepted rising edge and
  // derives period, count and timeout from edge times.
  typedef struct packed {
    logic [7:0]  hist;
    logic        has_ref;
    logic [63:0] last_t;
    logic [63:0] edges;
    logic [63:0] period;
    logic        to;
    logic        edge_s;
    logic        valid;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t mdl_next(mdl_t m, logic pin, logic clr, longint n, int w, longint tmo);
    mdl_t        r    = m;
    logic [63:0] maxv = (64'd1 << w) - 64'd1;
    logic [63:0] gap  = 64'(n) - m.last_t;
    logic        rise;
    r.hist   = {m.hist[6:0], pin};
    rise     = r.hist[c_SYNC] & ~r.hist[c_SYNC+1];
    r.edge_s = 1'b0;
    r.valid  = 1'b0;
    if (clr) begin
      r.has_ref = 1'b0; r.edges = '0; r.period = '0; r.to = 1'b0;
    end else if (rise) begin
      r.edge_s = 1'b1;
      r.edges  = (m.edges + 64'd1) & maxv;
      if (m.has_ref) begin
        r.valid  = 1'b1;
        r.period = (gap > maxv) ? maxv : gap;
      end
      r.has_ref = 1'b1;
      r.last_t  = 64'(n);
      r.to      = 1'b0;
    end else if (m.has_ref && gap >= 64'(tmo)) begin
      r.to      = 1'b1;
      r.has_ref = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mdl_next(ma, bus_a.pulse_in, bus_a.clear, cyc + 1, 32, 50);
      mb <= mdl_next(mb, bus_b.pulse_in, bus_b.clear, cyc + 1, 4, 100000);
    end
  end

  logic [66:0] obs_a, exp_a;
  logic [10:0] obs_b, exp_b;
  assign obs_a = {bus_a.edge_strobe, bus_a.period_valid, bus_a.timeout, bus_a.period_out, bus_a.pulse_count};
  assign exp_a = {ma.edge_s, ma.valid, ma.to, ma.period[31:0], ma.edges[31:0]};
  assign obs_b = {bus_b.edge_strobe, bus_b.period_valid, bus_b.timeout, bus_b.period_out, bus_b.pulse_count};
  assign exp_b = {mb.edge_s, mb.valid, mb.to, mb.period[3:0], mb.edges[3:0]};

  task automatic cyc_a(input logic p, input logic c);
    @(negedge clk);
    bus_a.pulse_in = p;
    bus_a.clear    = c;
  endtask

  task automatic cyc_b(input logic p, input logic c);
    @(negedge clk);
    bus_b.pulse_in = p;
    bus_b.clear    = c;
  endtask

  task automatic settle_at(input longint t);
    longint tt = t;
    if (tt % 10 == 5) tt++;
    if (tt > $time) #(tt - $time);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (obs_a !== '0) begin errs++; $display("FAIL reset_a got %h expected 0", obs_a); end
    checks++; if (obs_b !== '0) begin errs++; $display("FAIL reset_b got %h expected 0", obs_b); end
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b0);
    checks++; if (obs_a !== exp_a) begin errs++; $display("FAIL reset_model_a got %h expected %h", obs_a, exp_a); end
  endtask

  task automatic test_square;
    longint s_cyc[$];
    logic   v[$];
    logic [31:0] per[$];
    longint first_s = 0;
    for (int i = 0; i < 60; i++) begin
      cyc_a((i < 40) && (i % 10 < 5), 1'b0);
      if (i == 0) first_s = cyc + 1;
      if (bus_a.edge_strobe) begin s_cyc.push_back(cyc); v.push_back(bus_a.period_valid); per.push_back(bus_a.period_out); end
      checks++; if (obs_a !== exp_a) begin errs++; $display("FAIL square_model cyc=%0d got %h expected %h", cyc, obs_a, exp_a); end
    end
    checks++; if (s_cyc.size() != 4) begin errs++; $display("FAIL square_edges got %0d expected 4", s_cyc.size()); end
    if (s_cyc.size() > 0) begin
      // strobe lands on the (SYNC_STAGES+1)-th edge counting the sampling edge
      checks++; if (s_cyc[0] != first_s + c_SYNC) begin errs++; $display("FAIL square_latency got %0d expected %0d", s_cyc[0], first_s + c_SYNC); end
      checks++; if (v[0] !== 1'b0) begin errs++; $display("FAIL square_first_valid got %b expected 0", v[0]); end
    end
    for (int j = 1; j < s_cyc.size(); j++) begin
      checks++; if (v[j] !== 1'b1 || per[j] !== 32'd10) begin errs++; $display("FAIL square_period edge=%0d got valid=%b period=%0d expected valid=1 period=10", j + 1, v[j], per[j]); end
    end
    checks++; if (bus_a.pulse_count !== 32'd4) begin errs++; $display("FAIL square_count got %0d expected 4", bus_a.pulse_count); end
  endtask

  task automatic test_timeout;
    longint last_s = -1, to_cyc = -1;
    logic [31:0] last_per = '0;
    logic prev_to;
    int n = 0;
    cyc_a(1'b0, 1'b1);
    cyc_a(1'b0, 1'b0);
    checks++; if (bus_a.pulse_count !== 32'd0 || bus_a.timeout !== 1'b0) begin errs++; $display("FAIL timeout_preclear got count=%0d to=%b expected 0 0", bus_a.pulse_count, bus_a.timeout); end
    for (int k = 0; k < 144; k++) begin
      cyc_a((k < 24) && (k % 8 < 4), 1'b0);
      if (bus_a.edge_strobe) begin last_s = cyc; last_per = bus_a.period_out; end
      checks++; if (obs_a !== exp_a) begin errs++; $display("FAIL timeout_model cyc=%0d got %h expected %h", cyc, obs_a, exp_a); end
      if (bus_a.timeout) begin to_cyc = cyc; break; end
    end
    checks++; if (to_cyc - last_s != 50) begin errs++; $display("FAIL timeout_delay got %0d expected 50", to_cyc - last_s); end
    checks++; if (last_per !== 32'd8 || bus_a.period_out !== 32'd8) begin errs++; $display("FAIL timeout_period got %0d/%0d expected 8", last_per, bus_a.period_out); end
    prev_to = bus_a.timeout;
    for (int k = 0; k < 40; k++) begin
      cyc_a((k < 18) && (k % 12 < 6), 1'b0);
      if (bus_a.edge_strobe) begin
        n++;
        if (n == 1) begin
          checks++; if (prev_to !== 1'b1 || bus_a.timeout !== 1'b0 || bus_a.period_valid !== 1'b0 || bus_a.period_out !== 32'd8) begin
            errs++; $display("FAIL timeout_rearm got prev_to=%b to=%b valid=%b period=%0d expected 1 0 0 8", prev_to, bus_a.timeout, bus_a.period_valid, bus_a.period_out);
          end
        end else if (n == 2) begin
          checks++; if (bus_a.period_valid !== 1'b1 || bus_a.period_out !== 32'd12) begin errs++; $display("FAIL timeout_next_period got valid=%b period=%0d expected 1 12", bus_a.period_valid, bus_a.period_out); end
        end
      end
      prev_to = bus_a.timeout;
    end
    checks++; if (n != 2) begin errs++; $display("FAIL timeout_edges got %0d expected 2", n); end
  endtask

  task automatic test_clear;
    int n = 0;
    repeat (4) cyc_a(1'b0, 1'b0);
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b1, 1'b1);
    cyc_a(1'b1, 1'b0);
    checks++; if ({bus_a.edge_strobe, bus_a.period_valid, bus_a.timeout} !== 3'b000 || bus_a.pulse_count !== 32'd0 || bus_a.period_out !== 32'd0) begin
      errs++; $display("FAIL clear_vs_rise got %h expected all zero", obs_a);
    end
    cyc_a(1'b1, 1'b0);
    checks++; if (bus_a.edge_strobe !== 1'b0) begin errs++; $display("FAIL clear_late_strobe got 1 expected 0"); end
    for (int k = 0; k < 14; k++) begin
      cyc_a((k >= 4) && (k < 8), 1'b0);
      if (bus_a.edge_strobe) begin
        n++;
        checks++; if (bus_a.period_valid !== 1'b0 || bus_a.pulse_count !== 32'd1) begin errs++; $display("FAIL clear_next_edge got valid=%b count=%0d expected 0 1", bus_a.period_valid, bus_a.pulse_count); end
      end
      checks++; if (obs_a !== exp_a) begin errs++; $display("FAIL clear_model cyc=%0d got %h expected %h", cyc, obs_a, exp_a); end
    end
    checks++; if (n != 1) begin errs++; $display("FAIL clear_edges got %0d expected 1", n); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    for (int k = 0; k < 43; k++) cyc_a((k < 15) && (k % 10 < 5), 1'b0);
    checks++; if (bus_a.period_out !== 32'd10 || bus_a.pulse_count !== 32'd3) begin errs++; $display("FAIL rstmid_before got period=%0d count=%0d expected 10 3", bus_a.period_out, bus_a.pulse_count); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs_a !== '0) begin errs++; $display("FAIL rstmid_async got %h expected 0", obs_a); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc_a((k < 14) && (k % 9 < 5), 1'b0);
      if (bus_a.edge_strobe) begin
        n++;
        if (n == 1) begin
          checks++; if (bus_a.period_valid !== 1'b0 || bus_a.pulse_count !== 32'd1) begin errs++; $display("FAIL rstmid_first got valid=%b count=%0d expected 0 1", bus_a.period_valid, bus_a.pulse_count); end
        end else begin
          checks++; if (bus_a.period_valid !== 1'b1 || bus_a.period_out !== 32'd9) begin errs++; $display("FAIL rstmid_second got valid=%b period=%0d expected 1 9", bus_a.period_valid, bus_a.period_out); end
        end
      end
    end
    checks++; if (n != 2) begin errs++; $display("FAIL rstmid_edges got %0d expected 2", n); end
  endtask

  task automatic test_jitter;
    int per[$];
    int got[$];
    int nstrobe = 0;
    cyc_a(1'b0, 1'b1);
    cyc_a(1'b0, 1'b0);
    fork
      begin
        longint t = $time + longint'($urandom_range(3, 30));
        for (int r = 0; r < 10; r++) begin
          int p = int'($urandom_range(7, 9));
          settle_at(t);
          bus_a.pulse_in = 1'b1;
          settle_at(t + p * 5 - 2 + longint'($urandom_range(0, 4)));
          bus_a.pulse_in = 1'b0;
          if (r < 9) per.push_back(p);
          t = t + p * 10;
        end
      end
      begin
        for (int k = 0; k < 140; k++) begin
          @(negedge clk);
          if (bus_a.edge_strobe) nstrobe++;
          if (bus_a.period_valid) got.push_back(int'(bus_a.period_out));
          checks++; if (obs_a !== exp_a) begin errs++; $display("FAIL jitter_model cyc=%0d got %h expected %h", cyc, obs_a, exp_a); end
        end
      end
    join
    checks++; if (nstrobe != 10) begin errs++; $display("FAIL jitter_edges got %0d expected 10", nstrobe); end
    checks++; if (got.size() != per.size()) begin errs++; $display("FAIL jitter_valids got %0d expected %0d", got.size(), per.size()); end
    for (int j = 0; j < got.size() && j < per.size(); j++) begin
      checks++; if (got[j] < per[j] - 1 || got[j] > per[j] + 1) begin errs++; $display("FAIL jitter_period idx=%0d got %0d expected %0d+-1", j, got[j], per[j]); end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] cnt[$];
    logic [3:0] per[$];
    logic       v[$];
    for (int k = 0; k < 100; k++) begin
      cyc_b(((k < 64) && (k % 4 < 2)) || (k >= 80 && k < 82), 1'b0);
      if (bus_b.edge_strobe) begin cnt.push_back(bus_b.pulse_count); per.push_back(bus_b.period_out); v.push_back(bus_b.period_valid); end
      checks++; if (obs_b !== exp_b) begin errs++; $display("FAIL wrap_model cyc=%0d got %h expected %h", cyc, obs_b, exp_b); end
    end
    checks++; if (cnt.size() != 17) begin errs++; $display("FAIL wrap_edges got %0d expected 17", cnt.size()); end
    if (cnt.size() == 17) begin
      checks++; if (cnt[14] !== 4'd15 || cnt[15] !== 4'd0 || cnt[16] !== 4'd1) begin errs++; $display("FAIL wrap_count got %0d,%0d,%0d expected 15,0,1", cnt[14], cnt[15], cnt[16]); end
      checks++; if (v[1] !== 1'b1 || per[1] !== 4'd4) begin errs++; $display("FAIL wrap_short_period got valid=%b period=%0d expected 1 4", v[1], per[1]); end
      checks++; if (v[16] !== 1'b1 || per[16] !== 4'd15) begin errs++; $display("FAIL wrap_saturate got valid=%b period=%0d expected 1 15", v[16], per[16]); end
    end
  endtask

  initial begin
    bus_a.pulse_in = 1'b0; bus_a.clear = 1'b0;
    bus_b.pulse_in = 1'b0; bus_b.clear = 1'b0;
    test_reset();
    test_square();
    test_timeout();
    test_clear();
    test_reset_mid();
    test_jitter();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
